// File: rtl/uart_cmd_decoder.sv
// uart_cmd_decoder: pops ASCII command bytes from the RX FIFO, emits button-equivalent pulses and echo bytes
module uart_cmd_decoder #(
  parameter bit ECHO_EN = 1'b1,
  parameter logic [7:0] ERR_CHAR = 8'h3F
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_empty,
  input  logic [7:0] rx_data,
  output logic       rx_pop,
  input  logic       tx_full,
  output logic [7:0] tx_data,
  output logic       tx_push,
  output logic       mode_stpw,
  output logic       run_stop,
  output logic       clear,
  output logic       hour_up,
  output logic       min_up,
  output logic       sec_up,
  output logic       cmd_err
);
  typedef enum logic [1:0] {IDLE, FETCH, EXEC, ECHO} state_t;
  state_t state, state_nx;
  logic [7:0] cmd_reg, lc;
  logic is_m, is_r, is_c, is_h, is_n, is_s, is_nl, known, exec;
  // classify the held command; OR-ing 0x20 folds upper-case letters onto lower-case
  always_comb begin
    lc = cmd_reg | 8'h20;
    is_m = lc == 8'h6D;
    is_r = lc == 8'h72;
    is_c = lc == 8'h63;
    is_h = lc == 8'h68;
    is_n = lc == 8'h6E;
    is_s = lc == 8'h73;
    is_nl = cmd_reg == 8'h0D || cmd_reg == 8'h0A;
    known = is_m | is_r | is_c | is_h | is_n | is_s;
  end
  assign exec = state == EXEC;
  assign rx_pop = state == FETCH;
  assign tx_push = state == ECHO && !tx_full;
  assign run_stop = exec && is_r;
  assign clear = exec && is_c;
  assign hour_up = exec && is_h;
  assign min_up = exec && is_n;
  assign sec_up = exec && is_s;
  assign cmd_err = exec && !known && !is_nl;
  // next state: line terminators skip the echo, a full TX FIFO holds the echo
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = rx_empty ? IDLE : FETCH;
      FETCH:   state_nx = EXEC;
      EXEC:    state_nx = (ECHO_EN && !is_nl) ? ECHO : IDLE;
      ECHO:    state_nx = tx_full ? ECHO : IDLE;
      default: state_nx = IDLE;
    endcase
  end
  // state, latched command, mode level and echo byte (prepared during EXEC so it is stable throughout ECHO)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cmd_reg <= 8'h00;
      mode_stpw <= 1'b0;
      tx_data <= 8'h00;
    end else begin
      state <= state_nx;
      if (state == FETCH) cmd_reg <= rx_data;
      if (exec && is_m) mode_stpw <= ~mode_stpw;
      if (exec && ECHO_EN && !is_nl) tx_data <= known ? cmd_reg : ERR_CHAR;
    end
  end
endmodule

// File: tb/tb_uart_cmd_decoder.sv
// tb_uart_cmd_decoder: directed checks of command decode, pulse timing, echo and back-pressure
module tb_uart_cmd_decoder;
  logic clk = 1'b0, rst = 1'b1, rx_empty = 1'b1, tx_full = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic rx_pop, tx_push, mode_stpw, run_stop, clear, hour_up, min_up, sec_up, cmd_err;
  logic [7:0] tx_data;
  logic [5:0] pulses;
  logic [7:0] rxq[$];
  logic [7:0] b2b_tx [3] = '{8'h72, 8'h63, 8'h4D};
  logic [7:0] rcrc [4] = '{8'h72, 8'h63, 8'h72, 8'h63};
  logic [5:0] rcrc_p [4] = '{6'h20, 6'h10, 6'h20, 6'h10};
  int errors = 0, checks = 0;

  uart_cmd_decoder #(.ECHO_EN(1'b1), .ERR_CHAR(8'h3F)) dut (
    .clk(clk), .rst(rst), .rx_empty(rx_empty), .rx_data(rx_data), .rx_pop(rx_pop),
    .tx_full(tx_full), .tx_data(tx_data), .tx_push(tx_push), .mode_stpw(mode_stpw),
    .run_stop(run_stop), .clear(clear), .hour_up(hour_up), .min_up(min_up),
    .sec_up(sec_up), .cmd_err(cmd_err)
  );

  always #5 clk = ~clk;
  assign pulses = {run_stop, clear, hour_up, min_up, sec_up, cmd_err};

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic refresh();
    rx_empty = rxq.size() == 0;
    rx_data = rx_empty ? 8'h00 : rxq[0];
  endtask

  task automatic send(input logic [7:0] b);
    rxq.push_back(b);
    refresh();
  endtask

  task automatic step();
    logic p;
    p = rx_pop;
    @(posedge clk);
    #1;
    if (p) rxq.delete(0);
    refresh();
  endtask

  task automatic exec_cmd(input logic [5:0] p, input bit echo, input logic [7:0] t);
    step();
    chk("fetch_pop", 8'(rx_pop), 8'h01);
    chk("fetch_pulses", 8'(pulses), 8'h00);
    step();
    chk("exec_pulses", 8'(pulses), 8'(p));
    chk("exec_pop", 8'(rx_pop), 8'h00);
    chk("exec_push", 8'(tx_push), 8'h00);
    step();
    if (echo) begin
      chk("echo_push", 8'(tx_push), 8'h01);
      chk("echo_data", tx_data, t);
      chk("echo_pulses", 8'(pulses), 8'h00);
      step();
    end
    chk("idle_push", 8'(tx_push), 8'h00);
    chk("idle_pulses", 8'(pulses), 8'h00);
  endtask

  task automatic run_cmd(input logic [7:0] b, input logic [5:0] p, input bit echo, input logic [7:0] t);
    send(b);
    exec_cmd(p, echo, t);
  endtask

  task automatic all_zero(input string tag);
    chk({tag, "_pulses"}, 8'(pulses), 8'h00);
    chk({tag, "_pop"}, 8'(rx_pop), 8'h00);
    chk({tag, "_push"}, 8'(tx_push), 8'h00);
    chk({tag, "_mode"}, 8'(mode_stpw), 8'h00);
    chk({tag, "_txdata"}, tx_data, 8'h00);
  endtask

  initial begin
    #1;
    all_zero("reset");
    step();
    step();
    rst = 1'b0;
    step();
    all_zero("post_reset");
    // M toggles mode on, second M toggles it back
    run_cmd(8'h4D, 6'h00, 1'b1, 8'h4D);
    chk("mode_after_M", 8'(mode_stpw), 8'h01);
    run_cmd(8'h4D, 6'h00, 1'b1, 8'h4D);
    chk("mode_after_MM", 8'(mode_stpw), 8'h00);
    // r c r c with idle gaps
    for (int i = 0; i < 4; i++) begin
      run_cmd(rcrc[i], rcrc_p[i], 1'b1, rcrc[i]);
      step();
      step();
      chk("gap_pulses", 8'(pulses), 8'h00);
      chk("gap_mode", 8'(mode_stpw), 8'h00);
    end
    // remaining commands, upper and lower case
    run_cmd(8'h48, 6'h08, 1'b1, 8'h48);
    run_cmd(8'h6E, 6'h04, 1'b1, 8'h6E);
    run_cmd(8'h53, 6'h02, 1'b1, 8'h53);
    run_cmd(8'h43, 6'h10, 1'b1, 8'h43);
    // back-to-back r c M: pops every 4 cycles, pulse 1 cycle after each pop
    send(8'h72);
    send(8'h63);
    send(8'h4D);
    for (int i = 1; i <= 12; i++) begin
      step();
      chk("b2b_pop", 8'(rx_pop), 8'((i % 4 == 1) && i <= 9));
      chk("b2b_pulses", 8'(pulses), (i == 2) ? 8'h20 : (i == 6) ? 8'h10 : 8'h00);
      chk("b2b_push", 8'(tx_push), 8'((i % 4 == 3) && i <= 11));
      if (i % 4 == 3) chk("b2b_txdata", tx_data, b2b_tx[i / 4]);
    end
    chk("b2b_mode", 8'(mode_stpw), 8'h01);
    // unknown byte then CR
    run_cmd(8'h78, 6'h01, 1'b1, 8'h3F);
    run_cmd(8'h0D, 6'h00, 1'b0, 8'h00);
    run_cmd(8'h0A, 6'h00, 1'b0, 8'h00);
    chk("nl_txdata_held", tx_data, 8'h3F);
    // TX back-pressure on the echo of c, with another byte waiting in RX
    tx_full = 1'b1;
    send(8'h63);
    send(8'h68);
    step();
    chk("bp_fetch_pop", 8'(rx_pop), 8'h01);
    step();
    chk("bp_clear", 8'(pulses), 8'h10);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("bp_push", 8'(tx_push), 8'h00);
      chk("bp_pop", 8'(rx_pop), 8'h00);
      chk("bp_pulses", 8'(pulses), 8'h00);
      chk("bp_txdata", tx_data, 8'h63);
    end
    tx_full = 1'b0;
    #1;
    chk("bp_release_push", 8'(tx_push), 8'h01);
    chk("bp_release_data", tx_data, 8'h63);
    step();
    chk("bp_after_push", 8'(tx_push), 8'h00);
    exec_cmd(6'h08, 1'b1, 8'h68);
    // reset during EXEC of M while mode is 1
    send(8'h4D);
    step();
    step();
    chk("rst_exec_pre", 8'(mode_stpw), 8'h01);
    rst = 1'b1;
    #1;
    all_zero("rst_exec");
    step();
    rst = 1'b0;
    step();
    all_zero("rst_exec_after");
    run_cmd(8'h6E, 6'h04, 1'b1, 8'h6E);
    chk("rst_exec_mode", 8'(mode_stpw), 8'h00);
    // reset while held in ECHO
    run_cmd(8'h6D, 6'h00, 1'b1, 8'h6D);
    chk("mode_before_echo_rst", 8'(mode_stpw), 8'h01);
    tx_full = 1'b1;
    send(8'h63);
    step();
    step();
    step();
    chk("rst_echo_pre_push", 8'(tx_push), 8'h00);
    rst = 1'b1;
    #1;
    all_zero("rst_echo");
    step();
    rst = 1'b0;
    tx_full = 1'b0;
    step();
    all_zero("rst_echo_after");
    run_cmd(8'h73, 6'h02, 1'b1, 8'h73);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
